// File: rtl/uart_hex_tx.sv
// Small generic word FIFO: circular buffer, pointers flushed on reset.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: push_rdy is !full only; no pass-through while full.
module uart_hex_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push;
    logic             pop;

    assign push_rdy  = (count != FULL);
    assign pop_vld   = (count != '0);
    assign push      = push_vld && push_rdy;
    assign pop       = pop_rdy && pop_vld;
    assign pop_dat   = mem[rd_ptr];
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    assign empty_nxt = (count_nxt == '0);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end
endmodule

// Renders buffered 32-bit words as ASCII hex lines into a uart_tx byte interface.
// Latency: push to first o_tx_en is 3 cycles when uart_tx has been quiet; done to next byte is 2.
// Backpressure: o_ready = !full of the word FIFO; bytes are paced by i_tx_done.
module uart_hex_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PREFIX_EN  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_en,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic        o_idle
);
    localparam logic [3:0] LAST = (PREFIX_EN != 0) ? 4'd11 : 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t      state;
    logic [31:0] hold;
    logic [3:0]  byte_idx;
    logic [1:0]  quiet;

    logic        fifo_vld;
    logic [31:0] fifo_dat;
    logic        fifo_empty_nxt;
    logic        pop_ok;
    logic        pop_fire;
    logic        line_end;
    logic        idle_nxt;

    assign pop_ok   = (state == S_IDLE) && (quiet == 2'd2);
    assign pop_fire = pop_ok && fifo_vld;
    assign line_end = (state == S_WAIT) && i_tx_done && (byte_idx == LAST);
    assign idle_nxt = fifo_empty_nxt && (((state == S_IDLE) && !pop_fire) || line_end);

    uart_hex_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push_vld  (i_valid),
        .push_dat  (i_data),
        .push_rdy  (o_ready),
        .pop_rdy   (pop_ok),
        .pop_vld   (fifo_vld),
        .pop_dat   (fifo_dat),
        .empty_nxt (fifo_empty_nxt)
    );

    // pos is the digit position once the optional "0x" is skipped; 8/9 are CR/LF.
    function automatic logic [7:0] line_char(input logic [31:0] word, input logic [3:0] idx);
        logic [3:0] pos;
        logic [3:0] nib;
        pos = (PREFIX_EN != 0) ? idx - 4'd2 : idx;
        nib = 4'(word >> {~pos[2:0], 2'b00});
        if ((PREFIX_EN != 0) && (idx == 4'd0)) begin
            line_char = 8'h30;
        end else if ((PREFIX_EN != 0) && (idx == 4'd1)) begin
            line_char = 8'h78;
        end else if (pos == 4'd8) begin
            line_char = 8'h0D;
        end else if (pos == 4'd9) begin
            line_char = 8'h0A;
        end else if (nib < 4'd10) begin
            line_char = 8'h30 + {4'h0, nib};
        end else begin
            line_char = 8'h37 + {4'h0, nib};
        end
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            byte_idx  <= '0;
            quiet     <= '0;
            o_tx_en   <= 1'b0;
            o_tx_data <= 8'h00;
            o_idle    <= 1'b1;
        end else begin
            o_idle <= idle_nxt;
            case (state)
                S_IDLE: begin
                    o_tx_en <= 1'b0;
                    // uart_tx is not reset with us, so wait out any byte still in flight.
                    if (i_tx_busy) begin
                        quiet <= 2'd0;
                    end else if (quiet != 2'd2) begin
                        quiet <= quiet + 2'd1;
                    end
                    if (pop_fire) begin
                        hold     <= fifo_dat;
                        byte_idx <= 4'd0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    o_tx_data <= line_char(hold, byte_idx);
                    o_tx_en   <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    o_tx_en <= 1'b0;
                    if (i_tx_done) begin
                        if (byte_idx == LAST) begin
                            quiet <= 2'd0;
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= S_SEND;
                        end
                    end
                end
                default: begin
                    o_tx_en <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
